pc_sched: RTL and testbench

Fetch-stage PC sequencer for the pipelined MIPS core. It owns the fetch PC register and selects the next PC from four sources: sequential +4, branch/jump redirect, exception entry and ERET return. It holds the PC on hazard stalls and instruction-memory wait, and queues one redirect that arrives while the PC is held. It sits between the hazard unit, the D-stage branch unit, CP0 and instruction memory.

---
 rtl/pc_sched.sv | 112 +++++++++++
 tb/tb_pc_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_sched.sv
// pc_sched: fetch-stage PC sequencer. Picks the next PC from sequential +4,
// branch/jump, exception entry or ERET return. Holds the PC on stall or
// instruction-memory wait, and remembers one redirect seen while held.
module pc_sched #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [PC_W-1:0] EXC_PC   = 32'h0000_4180
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_f,
  input  logic            imem_ready,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_req,
  input  logic            eret,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] pc_f,
  output logic            pend_valid,
  output logic            flush_d,
  output logic            adel_f
);

  typedef enum logic {RUN, PEND} state_t;
  // Encoding order matches priority, so a plain compare ranks requests.
  typedef enum logic [1:0] {SRC_NONE, SRC_BR, SRC_ERET, SRC_EXC} src_t;

  state_t          state, state_n;
  src_t            pend_src, pend_src_n, req_src, eff_src;
  logic [PC_W-1:0] pend_tgt, pend_tgt_n, req_tgt, eff_tgt, pc_n;
  logic            flush_n, hold;

  // Exception/ERET may break a hazard stall but never an imem wait.
  assign hold = !imem_ready | (stall_f & !exc_req & !eret);

  // Reduce this cycle's requests to the single winning one.
  always_comb begin
    req_src = SRC_NONE;
    req_tgt = '0;
    if (exc_req) begin
      req_src = SRC_EXC;
      req_tgt = EXC_PC;
    end else if (eret) begin
      req_src = SRC_ERET;
      req_tgt = epc;
    end else if (br_valid) begin
      req_src = SRC_BR;
      req_tgt = br_target;
    end
  end

  // Next-state / next-PC selection.
  always_comb begin
    state_n    = state;
    pc_n       = pc_f;
    pend_tgt_n = pend_tgt;
    pend_src_n = pend_src;
    flush_n    = 1'b0;
    eff_src    = pend_src;
    eff_tgt    = pend_tgt;
    case (state)
      RUN: begin
        if (!hold) begin
          pc_n    = (req_src != SRC_NONE) ? req_tgt : pc_f + PC_W'(4);
          flush_n = (req_src == SRC_EXC) || (req_src == SRC_ERET);
        end else if (req_src != SRC_NONE) begin
          pend_tgt_n = req_tgt;
          pend_src_n = req_src;
          state_n    = PEND;
        end
      end
      PEND: begin
        // Equal or higher priority newcomer replaces the queued redirect.
        if (req_src != SRC_NONE && req_src >= pend_src) begin
          eff_src = req_src;
          eff_tgt = req_tgt;
        end
        if (!hold) begin
          pc_n       = eff_tgt;
          flush_n    = (eff_src == SRC_EXC) || (eff_src == SRC_ERET);
          pend_src_n = SRC_NONE;
          state_n    = RUN;
        end else begin
          pend_tgt_n = eff_tgt;
          pend_src_n = eff_src;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // State, PC, pending slot and flush registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      pc_f     <= RESET_PC;
      pend_tgt <= '0;
      pend_src <= SRC_NONE;
      flush_d  <= 1'b0;
    end else begin
      state    <= state_n;
      pc_f     <= pc_n;
      pend_tgt <= pend_tgt_n;
      pend_src <= pend_src_n;
      flush_d  <= flush_n;
    end
  end

  assign pend_valid = (state == PEND);
  assign adel_f     = (pc_f[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_sched.sv
// tb_pc_sched: directed vectors for pc_sched. The driver pushes the expected
// post-edge outputs into a queue; a monitor pops and compares after each edge
// (or after an explicit async-reset probe).
module tb_pc_sched;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_f, imem_ready, br_valid, exc_req, eret;
  logic [PC_W-1:0] br_target, epc;
  logic [PC_W-1:0] pc_f;
  logic            pend_valid, flush_d, adel_f;

  typedef struct {
    string           nm;
    logic [PC_W-1:0] pc;
    logic            pend;
    logic            flush;
    logic            adel;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event chk_ev;

  pc_sched dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .imem_ready(imem_ready),
    .br_valid(br_valid), .br_target(br_target), .exc_req(exc_req),
    .eret(eret), .epc(epc), .pc_f(pc_f), .pend_valid(pend_valid),
    .flush_d(flush_d), .adel_f(adel_f)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per edge (or per async probe).
  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        if (pc_f !== e.pc || pend_valid !== e.pend || flush_d !== e.flush || adel_f !== e.adel) begin
          n_fail++;
          $display("FAIL %s: got pc=%h pend=%b flush=%b adel=%b, want pc=%h pend=%b flush=%b adel=%b",
                   e.nm, pc_f, pend_valid, flush_d, adel_f, e.pc, e.pend, e.flush, e.adel);
        end
      end
    end
  end

  function automatic void push(input string nm, input logic [PC_W-1:0] pc,
                               input logic pend, input logic flush);
    exp_t e;
    logic [PC_W-1:0] p;
    p       = pc;
    e.nm    = nm;
    e.pc    = pc;
    e.pend  = pend;
    e.flush = flush;
    e.adel  = (p[1:0] != 2'b00);
    sb.push_back(e);
  endfunction

  // Drive one cycle's inputs at negedge and queue the post-edge expectation.
  task automatic cyc(input string nm, input logic rst, input logic st, input logic rdy,
                     input logic bv, input logic [PC_W-1:0] bt,
                     input logic ex, input logic er, input logic [PC_W-1:0] ep,
                     input logic [PC_W-1:0] e_pc, input logic e_pend, input logic e_flush);
    @(negedge clk);
    reset      = rst;
    stall_f    = st;
    imem_ready = rdy;
    br_valid   = bv;
    br_target  = bt;
    exc_req    = ex;
    eret       = er;
    epc        = ep;
    push(nm, e_pc, e_pend, e_flush);
  endtask

  initial begin
    reset = 1'b0; stall_f = 1'b0; imem_ready = 1'b1; br_valid = 1'b0;
    br_target = '0; exc_req = 1'b0; eret = 1'b0; epc = '0;

    //   name        rst st rdy bv bt            ex er ep         pc            pend flush
    cyc("rst0",      0, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3000, 0, 0);
    cyc("rst1",      0, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3000, 0, 0);
    cyc("run1",      1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3004, 0, 0);
    cyc("run2",      1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3008, 0, 0);
    // stall hold
    cyc("stall1",    1, 1, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3008, 0, 0);
    cyc("stall2",    1, 1, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3008, 0, 0);
    cyc("stall3",    1, 1, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3008, 0, 0);
    cyc("unstall",   1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_300C, 0, 0);
    // branch during stall
    cyc("br_stall",  1, 1, 1, 1, 32'h3100,     0, 0, 32'h0,     32'h0000_300C, 1, 0);
    cyc("br_held",   1, 1, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_300C, 1, 0);
    cyc("br_go",     1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3100, 0, 0);
    cyc("br_seq",    1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3104, 0, 0);
    // exception overrides stall and kills pending branch
    cyc("br_pend2",  1, 1, 1, 1, 32'h3200,     0, 0, 32'h0,     32'h0000_3104, 1, 0);
    cyc("exc_ovr",   1, 1, 1, 0, 32'h0,        1, 0, 32'h0,     32'h0000_4180, 0, 1);
    cyc("exc_seq",   1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_4184, 0, 0);
    // exception waits for imem, then a latched exc does not bypass stall
    cyc("exc_wait",  1, 0, 0, 0, 32'h0,        1, 0, 32'h0,     32'h0000_4184, 1, 0);
    cyc("exc_stall", 1, 1, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_4184, 1, 0);
    cyc("exc_go",    1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_4180, 0, 1);
    cyc("exc_seq2",  1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_4184, 0, 0);
    // pending eret drops a lower-priority branch
    cyc("eret_wait", 1, 0, 0, 0, 32'h0,        0, 1, 32'h3204,  32'h0000_4184, 1, 0);
    cyc("br_drop",   1, 0, 0, 1, 32'h3300,     0, 0, 32'h0,     32'h0000_4184, 1, 0);
    cyc("eret_go",   1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3204, 0, 1);
    cyc("eret_seq",  1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3208, 0, 0);
    // eret beats branch in the same cycle
    cyc("eret_vs_br",1, 0, 1, 1, 32'h3300,     0, 1, 32'h3204,  32'h0000_3204, 0, 1);
    cyc("evb_seq",   1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3208, 0, 0);
    // equal-priority branch replaces pending branch
    cyc("brA_pend",  1, 1, 1, 1, 32'h3500,     0, 0, 32'h0,     32'h0000_3208, 1, 0);
    cyc("brB_repl",  1, 1, 1, 1, 32'h3600,     0, 0, 32'h0,     32'h0000_3208, 1, 0);
    cyc("brB_go",    1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3600, 0, 0);
    // misaligned target
    cyc("mis_br",    1, 0, 1, 1, 32'h3102,     0, 0, 32'h0,     32'h0000_3102, 0, 0);
    cyc("mis_seq",   1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3106, 0, 0);
    // wrap at top of address space
    cyc("top_br",    1, 0, 1, 1, 32'hFFFF_FFFC,0, 0, 32'h0,     32'hFFFF_FFFC, 0, 0);
    cyc("wrap",      1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_0000, 0, 0);
    // park a redirect, then async reset mid-cycle
    cyc("pend_pre",  1, 1, 1, 1, 32'h3700,     0, 0, 32'h0,     32'h0000_0000, 1, 0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    push("async_rst", 32'h0000_3000, 0, 0);
    -> chk_ev;
    #2;

    cyc("rst_hold",  0, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3000, 0, 0);
    cyc("post_rst",  1, 0, 1, 0, 32'h0,        0, 0, 32'h0,     32'h0000_3004, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
